// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, RV32I funct3 codes and
// the access-size decode used by both the FSM and the alignment logic.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_ILL} lsu_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants exist only for loads; anything else is illegal.
  function automatic lsu_size_t decode_size(input logic we, input logic [2:0] funct3);
    lsu_size_t sz;
    sz = SZ_ILL;
    case (funct3)
      F3_B:    sz = SZ_B;
      F3_H:    sz = SZ_H;
      F3_W:    sz = SZ_W;
      F3_BU:   sz = we ? SZ_ILL : SZ_B;
      F3_HU:   sz = we ? SZ_ILL : SZ_H;
      default: sz = SZ_ILL;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication and misalignment
// for the incoming request; lane extraction and extension for the load response.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_t   req_size,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] load_data
);

  logic [31:0]        lane;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    be         = '0;
    wdata_rep  = req_wdata;
    misaligned = 1'b0;
    case (req_size)
      SZ_B: begin
        be        = 4'b0001 << req_off;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        be         = req_off[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{req_wdata[15:0]}};
        misaligned = req_off[0];
      end
      SZ_W: begin
        be         = 4'b1111;
        misaligned = |req_off;
      end
      default: ;
    endcase
  end

  assign lane   = rsp_rdata >> {rsp_off, 3'b000};
  assign lane_b = lane[7:0];
  assign lane_h = lane[15:0];

  always_comb begin
    load_data = lane;
    case (rsp_funct3)
      F3_B:    load_data = 32'(lane_b);
      F3_H:    load_data = 32'(lane_h);
      F3_BU:   load_data = {24'd0, lane[7:0]};
      F3_HU:   load_data = {16'd0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: request/grant/response port driver with
// alignment and size checks, bus timeout and stall signalling.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lsu_req_valid,
  output logic        o_lsu_req_ready,
  input  logic        i_lsu_we,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_done,
  output logic        o_lsu_misaligned,
  output logic        o_lsu_err,
  output logic        o_lsu_busy,
  output logic        o_dmem_req,
  input  logic        i_dmem_gnt,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  lsu_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  lsu_size_t        req_size;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic [31:0]      load_c;
  logic             mis_c;
  logic             accept;
  logic             rsp_ok;
  logic             timeout;

  assign req_size = decode_size(i_lsu_we, i_lsu_funct3);

  lsu_align u_align (
    .req_size   (req_size),
    .req_off    (i_lsu_addr[1:0]),
    .req_wdata  (i_lsu_wdata),
    .be         (be_c),
    .wdata_rep  (wdata_c),
    .misaligned (mis_c),
    .rsp_funct3 (funct3_q),
    .rsp_off    (off_q),
    .rsp_rdata  (i_dmem_rdata),
    .load_data  (load_c)
  );

  assign o_lsu_req_ready = (state == IDLE);
  assign o_lsu_busy      = (state != IDLE);
  assign accept          = i_lsu_req_valid && (state == IDLE);
  assign rsp_ok          = (state == WAIT) && i_dmem_rvalid;
  // A response arriving in the last allowed cycle still wins over the timeout.
  assign timeout = ((state == REQ) || (state == WAIT)) && !rsp_ok &&
                   (cnt == CNT_W'(MAX_WAIT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = ((req_size == SZ_ILL) || mis_c) ? DONE : REQ;
      REQ:  if (timeout) state_nxt = DONE;
            else if (i_dmem_gnt) state_nxt = WAIT;
      WAIT: if (rsp_ok || timeout) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      funct3_q         <= '0;
      off_q            <= '0;
      o_lsu_rdata      <= '0;
      o_lsu_done       <= 1'b0;
      o_lsu_misaligned <= 1'b0;
      o_lsu_err        <= 1'b0;
      o_dmem_req       <= 1'b0;
      o_dmem_we        <= 1'b0;
      o_dmem_addr      <= '0;
      o_dmem_be        <= '0;
      o_dmem_wdata     <= '0;
    end else begin
      state            <= state_nxt;
      o_lsu_done       <= (state_nxt == DONE);
      o_lsu_err        <= (accept && (req_size == SZ_ILL)) || timeout;
      o_lsu_misaligned <= accept && (req_size != SZ_ILL) && mis_c;
      o_dmem_req       <= (state_nxt == REQ);
      if (accept) begin
        cnt      <= '0;
        funct3_q <= i_lsu_funct3;
        off_q    <= i_lsu_addr[1:0];
      end else if ((state == REQ) || (state == WAIT)) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (accept && (state_nxt == REQ)) begin
        o_dmem_we    <= i_lsu_we;
        o_dmem_addr  <= {i_lsu_addr[31:2], 2'b00};
        o_dmem_be    <= be_c;
        o_dmem_wdata <= wdata_c;
      end
      if (state_nxt == DONE) o_lsu_rdata <= (rsp_ok && !o_dmem_we) ? load_c : '0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses compared against a cycle-count/arithmetic reference model.
module tb_load_store_unit;

  localparam int unsigned MW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        misaligned;
  logic        err;
  logic        busy;
  logic        dmem_req;
  logic        gnt;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        rvalid;
  logic [31:0] dmem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MAX_WAIT(MW)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_lsu_req_valid  (valid),
    .o_lsu_req_ready  (ready),
    .i_lsu_we         (we),
    .i_lsu_funct3     (funct3),
    .i_lsu_addr       (addr),
    .i_lsu_wdata      (wdata),
    .o_lsu_rdata      (rdata),
    .o_lsu_done       (done),
    .o_lsu_misaligned (misaligned),
    .o_lsu_err        (err),
    .o_lsu_busy       (busy),
    .o_dmem_req       (dmem_req),
    .i_dmem_gnt       (gnt),
    .o_dmem_we        (dmem_we),
    .o_dmem_addr      (dmem_addr),
    .o_dmem_be        (dmem_be),
    .o_dmem_wdata     (dmem_wdata),
    .i_dmem_rvalid    (rvalid),
    .i_dmem_rdata     (dmem_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: access size in bytes, 0 when the funct3 is illegal.
  function automatic int ref_bytes(input logic w, input logic [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd4: return w ? 0 : 1;
      3'd5: return w ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] b;
    logic [31:0] h;
    sh = word >> (8 * a[1:0]);
    b  = sh % 256;
    h  = sh % 65536;
    case (f3)
      3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return word;
    endcase
  endfunction

  // Drives one access from IDLE; grant after gdly extra REQ cycles, response
  // after rdly extra WAIT cycles. Returns observations, ends back in IDLE.
  task automatic run_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int gdly, input int rdly,
                            input logic [31:0] rsp, input bit noise,
                            output int done_cyc, output logic [31:0] o_rdata,
                            output logic o_mis, output logic o_err, output int req_cyc,
                            output logic c_we, output logic [31:0] c_addr,
                            output logic [3:0] c_be, output logic [31:0] c_wdata,
                            output int bad);
    int  wait_cnt;
    bit  granted;
    done_cyc = -1; o_rdata = '0; o_mis = 1'b0; o_err = 1'b0; req_cyc = 0; bad = 0;
    c_we = 1'b0; c_addr = '0; c_be = '0; c_wdata = '0;
    wait_cnt = 0; granted = 1'b0;
    if (!ready) bad++;
    valid = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    tick;
    valid = 1'b0; we = $urandom_range(0, 1); funct3 = 3'($urandom_range(0, 7));
    addr = $urandom; wdata = $urandom;
    for (int c = 1; c <= 40; c++) begin
      gnt = 1'b0; rvalid = 1'b0; dmem_rdata = $urandom;
      if (!busy || ready) bad++;
      if (done) begin
        done_cyc = c; o_rdata = rdata; o_mis = misaligned; o_err = err;
        break;
      end
      if (misaligned || err) bad++;
      if (dmem_req) begin
        req_cyc++;
        c_we = dmem_we; c_addr = dmem_addr; c_be = dmem_be; c_wdata = dmem_wdata;
        gnt = (req_cyc - 1 == gdly);
        if (noise) rvalid = 1'($urandom_range(0, 1));
        if (gnt) granted = 1'b1;
      end else if (granted) begin
        rvalid = (wait_cnt == rdly);
        if (rvalid) dmem_rdata = rsp;
        wait_cnt++;
      end
      tick;
    end
    gnt = 1'b0; rvalid = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valid = 1'b0; we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    gnt = 1'b0; rvalid = 1'b0; dmem_rdata = '0;
    tick; tick;
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
    n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", dmem_req); end
    n_tests++; if ({dmem_we, dmem_be, misaligned, err} !== 7'd0) begin
      n_fail++; $display("FAIL rst_flags got we=%b be=%b mis=%b err=%b exp 0", dmem_we, dmem_be, misaligned, err);
    end
    n_tests++; if ({dmem_addr, dmem_wdata, rdata} !== 96'd0) begin
      n_fail++; $display("FAIL rst_data got addr=%h wdata=%h rdata=%h exp 0", dmem_addr, dmem_wdata, rdata);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_directed;
    int dc, rc, bad;
    logic [31:0] rd, ca, cw;
    logic m, e, cwe;
    logic [3:0] cb;
    run_access(1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, dc, rd, m, e, rc, cwe, ca, cb, cw, bad);
    n_tests++; if (ca !== 32'h100 || cb !== 4'hF) begin n_fail++; $display("FAIL lw_port got addr=%h be=%b exp 100/1111", ca, cb); end
    n_tests++; if (dc !== 3) begin n_fail++; $display("FAIL lw_latency got %0d exp 3", dc); end
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata got %h exp deadbeef", rd); end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL lw_busy_flags got %0d exp 0", bad); end
    run_access(1'b0, 3'd0, 32'h103, 32'h0, 0, 0, 32'h80123456, 1'b0, dc, rd, m, e, rc, cwe, ca, cb, cw, bad);
    n_tests++; if (cb !== 4'b1000 || ca !== 32'h100) begin n_fail++; $display("FAIL lb_port got addr=%h be=%b exp 100/1000", ca, cb); end
    n_tests++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata got %h exp ffffff80", rd); end
    run_access(1'b0, 3'd4, 32'h103, 32'h0, 0, 0, 32'h80123456, 1'b0, dc, rd, m, e, rc, cwe, ca, cb, cw, bad);
    n_tests++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_rdata got %h exp 00000080", rd); end
    run_access(1'b1, 3'd1, 32'h102, 32'h1234ABCD, 1, 1, 32'h55555555, 1'b0, dc, rd, m, e, rc, cwe, ca, cb, cw, bad);
    n_tests++; if (cwe !== 1'b1 || cb !== 4'b1100) begin n_fail++; $display("FAIL sh_port got we=%b be=%b exp 1/1100", cwe, cb); end
    n_tests++; if (cw !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata got %h exp abcdabcd", cw); end
    n_tests++; if (rd !== 32'h0 || dc !== 5) begin n_fail++; $display("FAIL sh_done got rdata=%h cyc=%0d exp 0/5", rd, dc); end
  endtask

  task automatic test_errors;
    int dc, rc, bad;
    logic [31:0] rd, ca, cw;
    logic m, e, cwe;
    logic [3:0] cb;
    run_access(1'b0, 3'd2, 32'h101, 32'h0, 0, 0, 32'h0, 1'b0, dc, rd, m, e, rc, cwe, ca, cb, cw, bad);
    n_tests++; if (rc !== 0 || dc !== 1) begin n_fail++; $display("FAIL mis_timing got req=%0d cyc=%0d exp 0/1", rc, dc); end
    n_tests++; if (m !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL mis_flags got mis=%b err=%b exp 1/0", m, e); end
    run_access(1'b1, 3'd3, 32'h200, 32'h0, 0, 0, 32'h0, 1'b0, dc, rd, m, e, rc, cwe, ca, cb, cw, bad);
    n_tests++; if (rc !== 0 || dc !== 1) begin n_fail++; $display("FAIL ill_timing got req=%0d cyc=%0d exp 0/1", rc, dc); end
    n_tests++; if (m !== 1'b0 || e !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL ill_flags got mis=%b err=%b rdata=%h exp 0/1/0", m, e, rd);
    end
  endtask

  task automatic test_timeout;
    int dc, rc, bad, pulses;
    logic [31:0] rd, ca, cw;
    logic m, e, cwe;
    logic [3:0] cb;
    run_access(1'b0, 3'd2, 32'h300, 32'h0, 1000, 0, 32'h0, 1'b0, dc, rd, m, e, rc, cwe, ca, cb, cw, bad);
    n_tests++; if (rc !== int'(MW)) begin n_fail++; $display("FAIL to_req_cycles got %0d exp %0d", rc, MW); end
    n_tests++; if (dc !== int'(MW) + 1 || e !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL to_done got cyc=%0d err=%b rdata=%h exp %0d/1/0", dc, e, rd, MW + 1);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; dmem_rdata = $urandom;
      tick;
      if (done || rdata !== 32'h0 || busy) pulses++;
    end
    rvalid = 1'b0;
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL late_rvalid got %0d reactions exp 0", pulses); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    valid = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h400;
    tick;
    valid = 1'b0;
    tick;
    tick;
    gnt = 1'b1;
    tick;
    gnt = 1'b0;
    n_tests++; if (dmem_req !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rm_in_wait got req=%b busy=%b exp 0/1", dmem_req, busy);
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    n_tests++; if (dmem_req !== 1'b0 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL rm_after got req=%b busy=%b ready=%b done=%b exp 0/0/1/0", dmem_req, busy, ready, done);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; dmem_rdata = $urandom;
      tick;
      if (done || busy) pulses++;
    end
    rvalid = 1'b0;
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL rm_no_done got %0d exp 0", pulses); end
  endtask

  task automatic test_random;
    int dc, rc, bad, g, r, nb, e_dc, e_rc;
    logic [31:0] rd, ca, cw, a, wd, rsp, e_rd, e_wd;
    logic m, e, cwe, w, e_m, e_e;
    logic [3:0] cb, e_be;
    logic [2:0] f3;
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      a = $urandom & ($urandom_range(0, 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      wd = $urandom; rsp = $urandom;
      g = $urandom_range(0, 3); r = $urandom_range(0, 2);
      nb = ref_bytes(w, f3);
      e_m = 1'b0; e_e = 1'b0; e_rd = '0; e_rc = 0;
      if (nb == 0) begin e_dc = 1; e_e = 1'b1; end
      else if (a % nb != 0) begin e_dc = 1; e_m = 1'b1; end
      else if (g + r + 2 > int'(MW)) begin
        e_dc = int'(MW) + 1; e_e = 1'b1; e_rc = (g + 1 < int'(MW)) ? g + 1 : int'(MW);
      end else begin
        e_dc = g + r + 3; e_rc = g + 1; e_rd = w ? 32'h0 : ref_load(f3, a, rsp);
      end
      e_be = (nb == 1) ? 4'(1 << (a % 4)) : (nb == 2) ? ((a % 4 >= 2) ? 4'hC : 4'h3) : 4'hF;
      e_wd = (nb == 1) ? (wd % 256) * 32'h0101_0101 : (nb == 2) ? (wd % 65536) * 32'h0001_0001 : wd;
      run_access(w, f3, a, wd, g, r, rsp, 1'b1, dc, rd, m, e, rc, cwe, ca, cb, cw, bad);
      n_tests++; if (dc !== e_dc) begin n_fail++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, dc, e_dc); end
      n_tests++; if ({m, e} !== {e_m, e_e}) begin n_fail++; $display("FAIL rnd%0d_flags got mis=%b err=%b exp %b/%b", i, m, e, e_m, e_e); end
      n_tests++; if (rd !== e_rd) begin n_fail++; $display("FAIL rnd%0d_rdata got %h exp %h", i, rd, e_rd); end
      n_tests++; if (rc !== e_rc) begin n_fail++; $display("FAIL rnd%0d_req_cycles got %0d exp %0d", i, rc, e_rc); end
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rnd%0d_busy_ready got %0d exp 0", i, bad); end
      if (e_rc > 0) begin
        n_tests++; if (cwe !== w || ca !== {a[31:2], 2'b00}) begin
          n_fail++; $display("FAIL rnd%0d_port got we=%b addr=%h exp %b/%h", i, cwe, ca, w, {a[31:2], 2'b00});
        end
        n_tests++; if (cb !== e_be || (w && cw !== e_wd)) begin
          n_fail++; $display("FAIL rnd%0d_lanes got be=%b wdata=%h exp %b/%h", i, cb, cw, e_be, e_wd);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_errors;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the RV32I datapath. It accepts one load/store per handshake from the execute/memory stage and drives a request/grant/response data-memory port with word-aligned address, byte enables and lane-replicated store data. It returns the aligned, sign- or zero-extended load word that feeds the writeback result-select mux. Alignment and illegal-size checks, a bus timeout, and a busy signal for the pipeline stall logic are included.

## Interface
- MAX_WAIT, 255: cycles allowed in REQ+WAIT before a timeout error; range 1..65535
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_lsu_req_valid  in  1  access request valid
- o_lsu_req_ready  out  1  high only in IDLE
- i_lsu_we  in  1  1 = store, 0 = load
- i_lsu_funct3  in  3  RV32I size/sign field (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- i_lsu_addr  in  32  byte address
- i_lsu_wdata  in  32  store data, right-justified
- o_lsu_rdata  out  32  extended load result; 0 for stores and errors; held until next done
- o_lsu_done  out  1  one-cycle completion pulse
- o_lsu_misaligned  out  1  valid with done: misaligned access
- o_lsu_err  out  1  valid with done: illegal funct3 or timeout
- o_lsu_busy  out  1  state != IDLE (stall request)
- o_dmem_req  out  1  request, held until granted
- i_dmem_gnt  in  1  grant
- o_dmem_we  out  1  write
- o_dmem_addr  out  32  {addr[31:2], 2'b00}
- o_dmem_be  out  4  byte enables
- o_dmem_wdata  out  32  replicated store data
- i_dmem_rvalid  in  1  response (read data or write ack)
- i_dmem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if valid & ready, latch we/funct3/addr/wdata.
  - Illegal funct3 (load 011/110/111, store >010): go to DONE with err=1, no memory access.
  - Misaligned (half: addr[0]!=0; word: addr[1:0]!=0): go to DONE with misaligned=1, no memory access.
  - Otherwise go to REQ.
- REQ: o_dmem_req=1; o_dmem_we/addr/be/wdata are stable from latched values. On i_dmem_gnt, go to WAIT. i_dmem_rvalid is ignored in REQ.
- WAIT: on i_dmem_rvalid, register the extracted result and go to DONE.
- DONE: o_lsu_done=1 for exactly one cycle, then IDLE.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
  - Loads drive the same enables.
- Store data: byte replicated ×4; half replicated ×2; word unchanged.
- Load extraction: lane = rdata >> (8*addr[1:0]). LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW is passed through.
- Timeout: a counter of width $clog2(MAX_WAIT+1) clears on accept and increments each cycle in REQ or WAIT. When it reaches MAX_WAIT without leaving WAIT, go to DONE with err=1 and rdata=0; o_dmem_req drops.
- i_dmem_rvalid outside WAIT, including late responses after a timeout, is ignored.
- Flags (misaligned, err) are mutually exclusive and valid only while done=1; otherwise 0.

## Timing
- Reset (i_rst_n=0 at an edge): state IDLE, counter 0. All outputs 0 except o_lsu_req_ready=1. o_dmem_addr/be/wdata are 0.
- Reset mid-operation abandons the access; o_dmem_req is 0 from the next cycle.
- Minimum latency: accept at cycle 0, REQ at 1 (gnt same cycle), WAIT at 2 (rvalid same cycle), done at cycle 3.
- Each grant-wait cycle or response-wait cycle adds 1.
- Error and misaligned completions: done at cycle 1.
- o_lsu_req_ready is combinational from state (state==IDLE). A new request can be accepted the cycle after done.
- o_lsu_busy=1 from the cycle after accept through the done cycle inclusive.
- All outputs except o_lsu_req_ready and o_lsu_busy are registered.

## Structure
- lsu_pkg holds:
  - state enum lsu_state_t
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - size-decode function returning byte/half/word/illegal
- Sub-module lsu_align (combinational): byte enables, store replication, misalignment check, load extraction and extension. Keep the FSM and counter in load_store_unit.

## Test plan
- LW addr 0x100, gnt in REQ, rvalid next with 0xDEADBEEF -> o_dmem_addr 0x100, be 1111, done at cycle 3, rdata 0xDEADBEEF.
- LB addr 0x103, rdata 0x80123456 -> be 1000, rdata 0xFFFFFF80. Same access as LBU -> rdata 0x00000080.
- SH addr 0x102, wdata 0x1234ABCD -> we=1, be 1100, o_dmem_wdata 0xABCDABCD, done after write ack, rdata 0.
- LW addr 0x101 -> o_dmem_req never asserts, done+misaligned at cycle 1. A store with funct3 011 -> done+err at cycle 1.
- MAX_WAIT=4, gnt held 0 -> req high 4 cycles then drops, done+err, rdata 0. A later rvalid in IDLE is ignored.
- gnt delayed 3 cycles, then i_rst_n=0 in WAIT -> next cycle req 0, busy 0, ready 1, done never pulses.
